// File: rtl/route_sched.sv
// Output-pixel window scheduler: walks an o_size x o_size grid and hands each window address to the router.
// Optional macro ROUTE_SCHED_ABORT_EN adds i_abort to cancel a pass from LOAD, ISSUE or GAP.
module route_sched #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_w_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_i_size,
    input  logic [ADDR_WIDTH-1:0] i_o_size,
    input  logic [ADDR_WIDTH-1:0] i_stride,
    input  logic                  i_router_done,
    output logic                  o_route_en,
    output logic [ADDR_WIDTH-1:0] o_i_start_addr,
    output logic [ADDR_WIDTH-1:0] o_w_start_addr,
    output logic [ADDR_WIDTH-1:0] o_out_row,
    output logic [ADDR_WIDTH-1:0] o_out_col,
    output logic                  o_busy,
    output logic                  o_done
`ifdef ROUTE_SCHED_ABORT_EN
    ,
    input  logic                  i_abort
`endif
);

    // state | meaning
    // IDLE  | waiting for i_start, outputs hold last pass values
    // LOAD  | latch config, clear counters, pick empty or non-empty pass
    // ISSUE | router enabled on current window until i_router_done
    // GAP   | one idle cycle between windows, counters already advanced
    // DONE  | one-cycle o_done pulse
    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, GAP, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] o_size_q;
    logic [ADDR_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0] row_step;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] last_idx;
    logic                  abort;

`ifdef ROUTE_SCHED_ABORT_EN
    assign abort = i_abort && (state == LOAD || state == ISSUE || state == GAP);
`else
    assign abort = 1'b0;
`endif

    assign last_idx = o_size_q - ADDR_WIDTH'(1);

    // o_i_start_addr and o_out_row/o_out_col double as the window address and counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= IDLE;
            o_size_q       <= '0;
            stride_q       <= '0;
            row_step       <= '0;
            row_base       <= '0;
            o_route_en     <= 1'b0;
            o_i_start_addr <= '0;
            o_w_start_addr <= '0;
            o_out_row      <= '0;
            o_out_col      <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            o_route_en <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state  <= LOAD;
                        o_busy <= 1'b1;
                    end
                end
                LOAD: begin
                    o_size_q       <= i_o_size;
                    stride_q       <= i_stride;
                    row_step       <= i_stride * i_i_size;
                    row_base       <= i_i_start_addr;
                    o_i_start_addr <= i_i_start_addr;
                    o_w_start_addr <= i_w_start_addr;
                    o_out_row      <= '0;
                    o_out_col      <= '0;
                    if (i_o_size == '0) begin
                        state  <= DONE;
                        o_done <= 1'b1;
                    end else begin
                        state      <= ISSUE;
                        o_route_en <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (i_router_done) begin
                        o_route_en <= 1'b0;
                        if (o_out_col == last_idx && o_out_row == last_idx) begin
                            state  <= DONE;
                            o_done <= 1'b1;
                        end else begin
                            state <= GAP;
                            if (o_out_col == last_idx) begin
                                o_out_col      <= '0;
                                o_out_row      <= o_out_row + ADDR_WIDTH'(1);
                                row_base       <= row_base + row_step;
                                o_i_start_addr <= row_base + row_step;
                            end else begin
                                o_out_col      <= o_out_col + ADDR_WIDTH'(1);
                                o_i_start_addr <= o_i_start_addr + stride_q;
                            end
                        end
                    end
                end
                GAP: begin
                    state      <= ISSUE;
                    o_route_en <= 1'b1;
                end
                DONE: begin
                    state  <= IDLE;
                    o_done <= 1'b0;
                    o_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_route_sched.sv
// Scoreboard bench for route_sched: expected windows queued per pass, popped on each route_en rise.
module tb_route_sched;

    localparam int MODE_NORMAL   = 0;
    localparam int MODE_RESET    = 1;
    localparam int MODE_SCRAMBLE = 2;
    localparam int MODE_ABORT    = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       router_done = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] i_start_addr = '0;
    logic [7:0] w_start_addr = '0;
    logic [7:0] i_size = '0;
    logic [7:0] o_size = '0;
    logic [7:0] stride = '0;
    logic       route_en;
    logic       busy;
    logic       done;
    logic [7:0] o_i_addr;
    logic [7:0] o_w_addr;
    logic [7:0] out_row;
    logic [7:0] out_col;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int addr;
        int row;
        int col;
    } win_t;

    win_t exp_q[$];

    always #5 clk = ~clk;

    route_sched #(.ADDR_WIDTH(8)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .i_i_start_addr (i_start_addr),
        .i_w_start_addr (w_start_addr),
        .i_i_size       (i_size),
        .i_o_size       (o_size),
        .i_stride       (stride),
        .i_router_done  (router_done),
        .o_route_en     (route_en),
        .o_i_start_addr (o_i_addr),
        .o_w_start_addr (o_w_addr),
        .o_out_row      (out_row),
        .o_out_col      (out_col),
        .o_busy         (busy),
        .o_done         (done)
`ifdef ROUTE_SCHED_ABORT_EN
        ,
        .i_abort        (abort)
`endif
    );

    task automatic chk(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_route_en"}, int'(route_en), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_i_addr"}, int'(o_i_addr), 0);
        chk({tag, "_w_addr"}, int'(o_w_addr), 0);
        chk({tag, "_row"}, int'(out_row), 0);
        chk({tag, "_col"}, int'(out_col), 0);
    endtask

    task automatic run_pass(input int base, input int w, input int isz, input int osz,
                            input int strd, input int mode);
        int   wins = 0;
        int   hi_run = 0;
        int   low_run = 0;
        int   cyc = 0;
        int   nwin;
        bit   prev_en = 1'b0;
        bit   fin = 1'b0;
        win_t e;
        exp_q.delete();
        for (int r = 0; r < osz; r++) begin
            for (int c = 0; c < osz; c++) begin
                e.addr = (base + r * strd * isz + c * strd) % 256;
                e.row  = r;
                e.col  = c;
                exp_q.push_back(e);
            end
        end
        nwin = osz * osz;
        @(negedge clk);
        i_start_addr = 8'(base);
        w_start_addr = 8'(w);
        i_size       = 8'(isz);
        o_size       = 8'(osz);
        stride       = 8'(strd);
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            router_done = 1'b0;
            start       = 1'b0;
            abort       = 1'b0;
            if (route_en && !prev_en) begin
                if (wins > 0) chk("gap_len", low_run, 1);
                if (exp_q.size() == 0) begin
                    chk("extra_window", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("win_addr", int'(o_i_addr), e.addr);
                    chk("win_row", int'(out_row), e.row);
                    chk("win_col", int'(out_col), e.col);
                    chk("w_addr", int'(o_w_addr), w);
                end
                wins++;
                hi_run = 0;
                if (mode == MODE_SCRAMBLE) begin
                    start        = 1'b1;
                    i_start_addr = 8'($urandom);
                    w_start_addr = 8'($urandom);
                    i_size       = 8'($urandom);
                    o_size       = 8'($urandom);
                    stride       = 8'($urandom);
                end
                if (mode == MODE_RESET && wins == 4) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk_all_zero("rst_mid");
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        chk("rst_no_done", int'(done), 0);
                    end
                    fin = 1'b1;
                end
            end
            if (!fin) begin
                if (route_en) begin
                    hi_run++;
                    low_run = 0;
                    if (hi_run == 3) router_done = 1'b1;
                end else begin
                    low_run++;
                end
                if (mode == MODE_ABORT && !route_en && busy && wins == 2) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    chk("abort_busy", int'(busy), 0);
                    chk("abort_route_en", int'(route_en), 0);
                    chk("abort_done", int'(done), 0);
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        chk("abort_no_done", int'(done), 0);
                    end
                    fin = 1'b1;
                end else if (done) begin
                    chk("win_count", wins, nwin);
                    chk("q_empty", exp_q.size(), 0);
                    @(negedge clk);
                    chk("done_pulse", int'(done), 0);
                    chk("idle_busy", int'(busy), 0);
                    fin = 1'b1;
                end else if (cyc > 2000) begin
                    chk("timeout", cyc, 0);
                    fin = 1'b1;
                end
            end
            prev_en = route_en;
        end
        exp_q.delete();
    endtask

    task automatic empty_pass();
        @(negedge clk);
        i_start_addr = 8'd7;
        w_start_addr = 8'd9;
        i_size       = 8'd4;
        o_size       = 8'd0;
        stride       = 8'd1;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("empty_busy1", int'(busy), 1);
        chk("empty_done1", int'(done), 0);
        chk("empty_en1", int'(route_en), 0);
        @(negedge clk);
        chk("empty_busy2", int'(busy), 1);
        chk("empty_done2", int'(done), 1);
        chk("empty_en2", int'(route_en), 0);
        @(negedge clk);
        chk("empty_busy3", int'(busy), 0);
        chk("empty_done3", int'(done), 0);
        chk("empty_en3", int'(route_en), 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        run_pass(0, 8'h40, 5, 3, 1, MODE_NORMAL);
        run_pass(0, 8'h11, 5, 2, 2, MODE_NORMAL);
        run_pass(250, 8'h22, 5, 2, 1, MODE_NORMAL);
        empty_pass();
        run_pass(0, 8'h40, 5, 3, 1, MODE_RESET);
        run_pass(0, 8'h40, 5, 3, 1, MODE_NORMAL);
        run_pass(0, 8'h33, 5, 3, 1, MODE_SCRAMBLE);
`ifdef ROUTE_SCHED_ABORT_EN
        run_pass(0, 8'h44, 5, 3, 1, MODE_ABORT);
        run_pass(3, 8'h55, 4, 2, 1, MODE_NORMAL);
`endif

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
